// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   start_i    request, sampled only in IDLE
//   kill_i     pipeline flush, aborts any operation in flight
//   op_i       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   data1_i    dividend (rs1)
//   data2_i    divisor (rs2)
//   busy_o     high while an operation is in flight (CALC/FIN)
//   done_o     one-cycle pulse, result_o valid in that cycle
//   result_o   quotient or remainder, held until the next done_o
module div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e            state_q, state_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode: sign handling, magnitudes and special-case detection
  logic            op_signed, op_rem, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    op_signed = ~op_i[0];
    op_rem    = op_i[1];
    a_neg     = op_signed & data1_i[XLEN-1];
    b_neg     = op_signed & data2_i[XLEN-1];
    // -INT_MIN wraps to INT_MIN, which is the correct unsigned magnitude
    mag_a     = a_neg ? XLEN'(-data1_i) : data1_i;
    mag_b     = b_neg ? XLEN'(-data2_i) : data2_i;
    div_zero  = (data2_i == '0);
    ovf       = op_signed && (data1_i == INT_MIN) && (data2_i == '1);
  end

  // One restoring step; the shifted partial remainder keeps its carry-out
  // bit so divisors above 2^(XLEN-1) compare correctly
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step, quo_fin, rem_fin;

  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    ge       = (rem_sh >= {1'b0, dvs_q});
    rem_step = ge ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ge};
    quo_fin  = neg_quo_q ? XLEN'(-quo_step) : quo_step;
    rem_fin  = neg_rem_q ? XLEN'(-rem_step) : rem_step;
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_i && !kill_i) begin
          is_rem_d  = op_rem;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dvs_d     = mag_b;
          busy_d    = 1'b1;
          if (div_zero) begin
            result_d = op_rem ? data1_i : '1;
            done_d   = 1'b1;
            state_d  = FIN;
          end else if (ovf) begin
            result_d = op_rem ? '0 : INT_MIN;
            done_d   = 1'b1;
            state_d  = FIN;
          end else begin
            quo_d   = mag_a;
            rem_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = is_rem_q ? rem_fin : quo_fin;
          done_d   = 1'b1;
          state_d  = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Flush overrides everything; the last delivered result stays visible
    if (kill_i) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus control-hazard sequences.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .kill_i   (kill),
    .op_i     (op),
    .data1_i  (data1),
    .data2_i  (data2),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vec[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request; latency counts edges from the START edge (inclusive)
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; data1 = a; data2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done after %0d cycles expected done", lat);
    end
    // FIN lasts one cycle, then the unit is idle with the result held
    @(posedge clk); #1;
    check("done_pulse_1cyc", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("result_hold", result, res);
  endtask

  logic [31:0] r;
  int          l;
  bit          saw_done;

  initial begin
    vec[0]  = '{"divu_100_7",   2'b01, 32'd100,      32'd7,        32'd14,       33};
    vec[1]  = '{"remu_100_7",   2'b11, 32'd100,      32'd7,        32'd2,        33};
    vec[2]  = '{"div_m7_2",     2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vec[3]  = '{"rem_m7_2",     2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vec[4]  = '{"div_7_m2",     2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vec[5]  = '{"rem_7_m2",     2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vec[6]  = '{"div_5_0",      2'b00, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vec[7]  = '{"remu_5_0",     2'b11, 32'd5,        32'd0,        32'd5,        1};
    vec[8]  = '{"div_ovf",      2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vec[9]  = '{"rem_ovf",      2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vec[10] = '{"divu_ovf_ops", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
    vec[11] = '{"remu_big_dvs", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        33};
    vec[12] = '{"div_min_2",    2'b00, 32'h80000000, 32'd2,        32'hC0000000, 33};

    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; data1 = '0; data2 = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(vec[i].op, vec[i].a, vec[i].b, r, l);
      check({vec[i].name, "_res"}, r, vec[i].res);
      check({vec[i].name, "_lat"}, 32'(l), 32'(vec[i].lat));
    end

    // START while busy is ignored; original operands complete
    @(negedge clk);
    start = 1'b1; op = 2'b01; data1 = 32'd100; data2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    l = 1;
    while (!done && l < 100) begin
      if (l == 10) begin
        start = 1'b1; op = 2'b00; data1 = 32'd50; data2 = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      l++;
    end
    start = 1'b0;
    check("ignore_start_res", result, 32'd14);
    check("ignore_start_lat", 32'(l), 32'd33);
    @(posedge clk); #1;

    // KILL mid-CALC: idle next cycle, no DONE, result held
    @(negedge clk);
    start = 1'b1; op = 2'b00; data1 = 32'd1000; data2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 15; c++) begin
      @(posedge clk); #1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_done", 32'(done), 32'd0);
    check("kill_result", result, 32'd14);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("kill_no_done", 32'(saw_done), 32'd0);

    // START with KILL in IDLE: no operation begins
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 2'b01; data1 = 32'd9; data2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_busy", 32'(busy), 32'd0);

    run_op(2'b01, 32'd1000, 32'd3, r, l);
    check("after_kill_res", r, 32'd333);
    check("after_kill_lat", 32'(l), 32'd33);

    // Async reset mid-CALC, between clock edges
    @(negedge clk);
    start = 1'b1; op = 2'b01; data1 = 32'd100; data2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 35; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("arst_no_done", 32'(saw_done), 32'd0);

    run_op(2'b01, 32'hFFFFFFFF, 32'd1, r, l);
    check("post_rst_res", r, 32'hFFFFFFFF);
    check("post_rst_lat", 32'(l), 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
